// File: rtl/dpsk_sym_tx.sv
// Byte-serial DPSK symbol transmitter: alternating preamble, LSB-first data, zero-level tail.
// Define DPSK_TX_DIFF_ENC_EN to drive tx_level from a differential phase register instead of NRZ.
`timescale 1ns/1ps
module dpsk_sym_tx #(
   parameter int OUT_WIDTH     = 6,
   parameter int OSR           = 8,
   parameter int SYS_CLK_FREQ  = 6400000,
   parameter int SAMPLE_RATE   = 800,
   parameter int PREAMBLE_BITS = 16,
   parameter int TAIL_SYMS     = 2
)(
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        enable,
   input  logic [7:0]                  tx_data,
   input  logic                        tx_valid,
   output logic                        tx_ready,
   output logic                        tx_busy,
   output logic                        sample_tick,
   output logic                        symbol_tick,
   output logic                        tx_bit,
   output logic signed [OUT_WIDTH-1:0] tx_level
);
   localparam int SAMPLE_DIV = SYS_CLK_FREQ / SAMPLE_RATE;
   localparam int DIV_W      = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
   localparam int OSR_W      = $clog2(OSR);
   localparam int MAX_A      = (PREAMBLE_BITS > TAIL_SYMS) ? PREAMBLE_BITS : TAIL_SYMS;
   localparam int MAX_SYMS   = (MAX_A > 8) ? MAX_A : 8;
   localparam int CNT_W      = $clog2(MAX_SYMS) + 1;
   localparam logic signed [OUT_WIDTH-1:0] LVL_P = {1'b0, {(OUT_WIDTH-1){1'b1}}};
   localparam logic signed [OUT_WIDTH-1:0] LVL_N = {1'b1, {(OUT_WIDTH-2){1'b0}}, 1'b1};

   typedef enum logic [1:0] {IDLE, PREAMBLE, DATA, TAIL} state_t;

   state_t                        state, state_n;
   logic [DIV_W-1:0]              div_cnt;
   logic [OSR_W-1:0]              samp_cnt;
   logic [CNT_W-1:0]              sym_cnt, sym_n;
   logic [7:0]                    shift_reg, shift_n;
   logic [7:0]                    hold_data;
   logic                          hold_full;
   logic                          load, drive, zero, bit_n, boundary, accept;
   logic signed [OUT_WIDTH-1:0]   level_n;
`ifdef DPSK_TX_DIFF_ENC_EN
   logic                          phase, phase_n;
`endif

   assign tx_ready = enable && !hold_full && !rst;
   assign tx_busy  = (state != IDLE);
   assign accept   = tx_valid && tx_ready;
   assign boundary = sample_tick && (samp_cnt == '0);

   always_ff @(posedge clk) begin
      if (rst) begin
         div_cnt     <= '0;
         sample_tick <= 1'b0;
      end else begin
         sample_tick <= (div_cnt == DIV_W'(SAMPLE_DIV - 1));
         div_cnt     <= (div_cnt == DIV_W'(SAMPLE_DIV - 1)) ? '0 : div_cnt + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= IDLE;
         samp_cnt    <= '0;
         sym_cnt     <= '0;
         shift_reg   <= '0;
         hold_data   <= '0;
         hold_full   <= 1'b0;
         tx_bit      <= 1'b0;
         tx_level    <= '0;
         symbol_tick <= 1'b0;
`ifdef DPSK_TX_DIFF_ENC_EN
         phase       <= 1'b0;
`endif
      end else begin
         state       <= state_n;
         sym_cnt     <= sym_n;
         shift_reg   <= shift_n;
         symbol_tick <= drive;
         tx_bit      <= bit_n;
         tx_level    <= level_n;
`ifdef DPSK_TX_DIFF_ENC_EN
         phase       <= phase_n;
`endif
         // The frame-start tick already counts as sample 0 of the first symbol.
         if (sample_tick)
            samp_cnt <= (state_n == IDLE) ? '0 : samp_cnt + 1'b1;
         // A same-cycle load consumes the old contents; the new byte refills the hold.
         if (accept) begin
            hold_data <= tx_data;
            hold_full <= 1'b1;
         end else if (load) begin
            hold_full <= 1'b0;
         end
      end
   end

   always_comb begin
      state_n = state;
      sym_n   = sym_cnt;
      shift_n = shift_reg;
      load    = 1'b0;
      drive   = 1'b0;
      zero    = 1'b0;
      bit_n   = tx_bit;
      case (state)
         IDLE: begin
            if (sample_tick && hold_full) begin
               state_n = PREAMBLE;
               sym_n   = '0;
               drive   = 1'b1;
               bit_n   = 1'b1;
            end
         end
         PREAMBLE: begin
            if (boundary) begin
               drive = 1'b1;
               if (sym_cnt == CNT_W'(PREAMBLE_BITS - 1)) begin
                  state_n = DATA;
                  load    = 1'b1;
                  shift_n = hold_data;
                  sym_n   = '0;
                  bit_n   = hold_data[0];
               end else begin
                  sym_n = sym_cnt + 1'b1;
                  bit_n = ~sym_n[0];
               end
            end
         end
         DATA: begin
            if (boundary) begin
               drive = 1'b1;
               if (sym_cnt == CNT_W'(7)) begin
                  sym_n = '0;
                  if (hold_full) begin
                     load    = 1'b1;
                     shift_n = hold_data;
                     bit_n   = hold_data[0];
                  end else begin
                     state_n = TAIL;
                     zero    = 1'b1;
                     bit_n   = 1'b0;
                  end
               end else begin
                  shift_n = shift_reg >> 1;
                  sym_n   = sym_cnt + 1'b1;
                  bit_n   = shift_n[0];
               end
            end
         end
         TAIL: begin
            if (boundary) begin
               if (sym_cnt == CNT_W'(TAIL_SYMS - 1)) begin
                  state_n = IDLE;
                  sym_n   = '0;
               end else begin
                  drive = 1'b1;
                  zero  = 1'b1;
                  sym_n = sym_cnt + 1'b1;
                  bit_n = 1'b0;
               end
            end
         end
         default: state_n = IDLE;
      endcase

      level_n = tx_level;
`ifdef DPSK_TX_DIFF_ENC_EN
      phase_n = phase;
`endif
      if (drive) begin
         if (zero) begin
            level_n = '0;
         end else begin
`ifdef DPSK_TX_DIFF_ENC_EN
            phase_n = (state == IDLE) ? 1'b0 : (phase ^ bit_n);
            level_n = phase_n ? LVL_P : LVL_N;
`else
            level_n = bit_n ? LVL_P : LVL_N;
`endif
         end
      end
   end
endmodule

// File: tb/tb_dpsk_sym_tx.sv
// Bench for dpsk_sym_tx: expected symbols are queued per frame and popped on every symbol_tick.
`timescale 1ns/1ps
module tb_dpsk_sym_tx;
   localparam int OUT_WIDTH     = 6;
   localparam int OSR           = 4;
   localparam int SYS_CLK_FREQ  = 64;
   localparam int SAMPLE_RATE   = 8;
   localparam int PREAMBLE_BITS = 4;
   localparam int TAIL_SYMS     = 2;
   localparam int DIV           = 8;
   localparam int SYM_CLK       = 32;
   localparam int FS            = 31;

   logic                        clk = 1'b0;
   logic                        rst = 1'b1;
   logic                        enable = 1'b1;
   logic [7:0]                  tx_data = '0;
   logic                        tx_valid = 1'b0;
   logic                        tx_ready, tx_busy, sample_tick, symbol_tick, tx_bit;
   logic signed [OUT_WIDTH-1:0] tx_level;

   typedef struct packed {
      logic                        b;
      logic signed [OUT_WIDTH-1:0] lvl;
   } sym_t;

   sym_t sb[$];
   sym_t mon_s;
   int   vectors = 0;
   int   miscompares = 0;
   int   cyc = 0;
   int   last_cyc = 0;
   bit   last_valid = 0;
   logic model_phase = 1'b0;

   dpsk_sym_tx #(
      .OUT_WIDTH(OUT_WIDTH), .OSR(OSR), .SYS_CLK_FREQ(SYS_CLK_FREQ),
      .SAMPLE_RATE(SAMPLE_RATE), .PREAMBLE_BITS(PREAMBLE_BITS), .TAIL_SYMS(TAIL_SYMS)
   ) dut (
      .clk(clk), .rst(rst), .enable(enable), .tx_data(tx_data), .tx_valid(tx_valid),
      .tx_ready(tx_ready), .tx_busy(tx_busy), .sample_tick(sample_tick),
      .symbol_tick(symbol_tick), .tx_bit(tx_bit), .tx_level(tx_level)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc++;

   task automatic push_sym(input logic b, input logic zero, input logic first);
      sym_t s;
      s.b = b;
      if (zero) s.lvl = '0;
      else begin
`ifdef DPSK_TX_DIFF_ENC_EN
         model_phase = first ? 1'b0 : (model_phase ^ b);
         s.lvl = model_phase ? OUT_WIDTH'(FS) : -OUT_WIDTH'(FS);
`else
         s.lvl = b ? OUT_WIDTH'(FS) : -OUT_WIDTH'(FS);
`endif
      end
      sb.push_back(s);
   endtask

   task automatic push_frame(input logic [15:0] data, input int nbytes);
      logic [7:0] by;
      for (int k = 0; k < PREAMBLE_BITS; k++) push_sym(~k[0], 1'b0, k == 0);
      for (int j = 0; j < nbytes; j++) begin
         by = data[8*j +: 8];
         for (int i = 0; i < 8; i++) push_sym(by[i], 1'b0, 1'b0);
      end
      for (int t = 0; t < TAIL_SYMS; t++) push_sym(1'b0, 1'b1, 1'b0);
   endtask

   always @(negedge clk) begin
      if (rst) last_valid = 0;
      else if (symbol_tick) begin
         vectors++;
         if (sb.size() == 0) begin
            miscompares++;
            $display("FAIL sym_extra: got bit=%0b level=%0d, required no symbol", tx_bit, tx_level);
         end else begin
            mon_s = sb.pop_front();
            if (tx_bit !== mon_s.b || tx_level !== mon_s.lvl) begin
               miscompares++;
               $display("FAIL sym_value: got bit=%0b level=%0d, required bit=%0b level=%0d",
                        tx_bit, tx_level, mon_s.b, mon_s.lvl);
            end
         end
         if (last_valid) begin
            vectors++;
            if (cyc - last_cyc != SYM_CLK) begin
               miscompares++;
               $display("FAIL sym_period: got %0d clk, required %0d", cyc - last_cyc, SYM_CLK);
            end
         end
         last_cyc   = cyc;
         last_valid = 1;
      end else if (!tx_busy) last_valid = 0;
   end

   task automatic wait_tick(output int n);
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!sample_tick && n < 50);
   endtask

   task automatic wait_syms(input int n);
      int seen = 0;
      int t = 0;
      while (seen < n && t < 3000) begin
         @(negedge clk);
         t++;
         if (symbol_tick) seen++;
      end
      vectors++;
      if (seen != n) begin
         miscompares++;
         $display("FAIL wait_syms: got %0d symbols, required %0d", seen, n);
      end
   endtask

   task automatic send_byte(input logic [7:0] b);
      int n = 0;
      while (!tx_ready && n < 3000) begin
         @(negedge clk);
         n++;
      end
      vectors++;
      if (!tx_ready) begin
         miscompares++;
         $display("FAIL send_ready: tx_ready=%0b required 1 for byte %02h", tx_ready, b);
      end else begin
         tx_valid = 1'b1;
         tx_data  = b;
         @(negedge clk);
         tx_valid = 1'b0;
      end
   endtask

   task automatic wait_done();
      int n = 0;
      while ((tx_busy || sb.size() != 0) && n < 5000) begin
         @(negedge clk);
         n++;
      end
      vectors++;
      if (tx_busy || sb.size() != 0) begin
         miscompares++;
         $display("FAIL frame_done: busy=%0b pending=%0d, required busy=0 pending=0", tx_busy, sb.size());
      end
   endtask

   task automatic test_reset();
      int n, m;
      rst = 1'b1; enable = 1'b1; tx_valid = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      vectors++;
      if ({tx_ready, tx_busy, sample_tick, symbol_tick, tx_bit} !== 5'b0) begin
         miscompares++;
         $display("FAIL reset_flags: got %05b, required 00000", {tx_ready, tx_busy, sample_tick, symbol_tick, tx_bit});
      end
      vectors++;
      if (tx_level !== '0) begin
         miscompares++;
         $display("FAIL reset_level: got %0d, required 0", tx_level);
      end
      rst = 1'b0;
      @(negedge clk);
      vectors++;
      if (tx_ready !== 1'b1) begin
         miscompares++;
         $display("FAIL ready_after_reset: got %0b, required 1", tx_ready);
      end
      wait_tick(m);
      n = m + 1;
      vectors++;
      if (n != DIV) begin
         miscompares++;
         $display("FAIL first_tick: got %0d clk, required %0d", n, DIV);
      end
      wait_tick(m);
      vectors++;
      if (m != DIV) begin
         miscompares++;
         $display("FAIL tick_period: got %0d clk, required %0d", m, DIV);
      end
   endtask

   task automatic test_single_a5();
      int lat = 0;
      int dur = 0;
      push_frame(16'h00A5, 1);
      send_byte(8'hA5);
      while (!tx_busy && lat < 20) begin
         @(negedge clk);
         lat++;
      end
      vectors++;
      if (lat < 1 || lat > DIV + 1) begin
         miscompares++;
         $display("FAIL start_latency: got %0d clk, required 1..%0d", lat, DIV + 1);
      end
      while (tx_busy && dur < 1000) begin
         dur++;
         @(negedge clk);
      end
      vectors++;
      if (dur != 14 * SYM_CLK) begin
         miscompares++;
         $display("FAIL busy_len: got %0d clk, required %0d", dur, 14 * SYM_CLK);
      end
      wait_done();
   endtask

   task automatic test_back_to_back();
      int low = 0;
      push_frame(16'h00FF, 2);
      send_byte(8'hFF);
      send_byte(8'h00);
      while (!tx_ready && low < 1000) begin
         low++;
         @(negedge clk);
      end
      vectors++;
      if (low != 8 * SYM_CLK - 1) begin
         miscompares++;
         $display("FAIL ready_low: got %0d clk, required %0d", low, 8 * SYM_CLK - 1);
      end
      wait_done();
   endtask

   task automatic test_enable();
      int bad = 0;
      enable = 1'b0; tx_valid = 1'b1; tx_data = 8'h5A;
      repeat (100) begin
         @(negedge clk);
         if (tx_ready || tx_busy) bad++;
      end
      vectors++;
      if (bad != 0) begin
         miscompares++;
         $display("FAIL enable_block: got %0d active cycles, required 0", bad);
      end
      tx_valid = 1'b0; enable = 1'b1;
      @(negedge clk);
      push_frame(16'h003C, 1);
      send_byte(8'h3C);
      wait_syms(6);
      enable = 1'b0; tx_valid = 1'b1; tx_data = 8'h77;
      wait_done();
      bad = 0;
      repeat (200) begin
         @(negedge clk);
         if (tx_ready || tx_busy) bad++;
      end
      vectors++;
      if (bad != 0) begin
         miscompares++;
         $display("FAIL enable_drop: got %0d active cycles, required 0", bad);
      end
      tx_valid = 1'b0; enable = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_reset_mid();
      push_frame(16'h0096, 1);
      send_byte(8'h96);
      wait_syms(PREAMBLE_BITS + 4);
      repeat (10) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      vectors++;
      if (tx_level !== '0) begin
         miscompares++;
         $display("FAIL midrst_level: got %0d, required 0", tx_level);
      end
      vectors++;
      if (tx_busy !== 1'b0) begin
         miscompares++;
         $display("FAIL midrst_busy: got %0b, required 0", tx_busy);
      end
      rst = 1'b0;
      sb.delete();
      @(negedge clk);
      push_frame(16'h0081, 1);
      send_byte(8'h81);
      wait_done();
   endtask

   task automatic test_level_03();
      push_frame(16'h0003, 1);
      send_byte(8'h03);
      wait_done();
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: time limit reached, required completion");
      $fatal(1);
   end

   initial begin
      test_reset();
      test_single_a5();
      test_back_to_back();
      test_enable();
      test_reset_mid();
      test_level_03();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
